// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: the occupancy state and the
// MEM/WB payload layout (71 bits) that the default stage width is sized for.
package pipe_pkg;

  localparam int unsigned MEMWB_W = 71;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic [31:0] alu_res;
    logic [4:0]  rd_addr;
    logic        wb;
    logic        wb_src;
  } memwb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid register and occupancy tracking for pipe_stage_elastic.
// Holds the second entry while the main register is stalled, and produces a
// registered ready so backpressure never forms a combinational path upstream.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH    = MEMWB_W,
  parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              accept_i,
  input  logic              pop_i,
  input  logic [WIDTH-1:0]  data_i,
  output pipe_state_e       state_o,
  output logic [WIDTH-1:0]  skid_data_o,
  output logic              ready_o
);

  pipe_state_e      r_state;
  logic [WIDTH-1:0] r_skid;
  logic             r_ready;

  assign state_o     = r_state;
  assign skid_data_o = r_skid;
  assign ready_o     = r_ready;

  // Occupancy FSM; ready is registered alongside the state (ready = state != TWO).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= EMPTY;
      r_skid  <= RST_DATA;
      r_ready <= 1'b1;
    end else if (flush_i) begin
      r_state <= EMPTY;
      r_skid  <= RST_DATA;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (accept_i) r_state <= ONE;
        end
        ONE: begin
          if (accept_i && !pop_i) begin
            r_state <= TWO;
            r_skid  <= data_i;
            r_ready <= 1'b0;
          end else if (pop_i && !accept_i) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (pop_i) begin
            r_state <= ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake and sync flush.
// Build option PIPE_STAGE_SKID_EN: adds a two-entry skid buffer with a
// registered in_ready_o; without it in_ready_o = !out_valid_o || out_ready_i.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH    = MEMWB_W,
  parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o
);

  logic [WIDTH-1:0] r_main;
  logic             r_vld;
  logic             w_accept;
  logic             w_pop;
  logic             w_load;
  logic [WIDTH-1:0] w_main_nxt;
  logic             w_vld_nxt;

  assign out_data_o  = r_main;
  assign out_valid_o = r_vld;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_pop       = r_vld && out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
  pipe_state_e      w_state;
  logic [WIDTH-1:0] w_skid_data;
  logic             w_ready;

  pipe_skid_buf #(
    .WIDTH    (WIDTH),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .accept_i    (w_accept),
    .pop_i       (w_pop),
    .data_i      (in_data_i),
    .state_o     (w_state),
    .skid_data_o (w_skid_data),
    .ready_o     (w_ready)
  );

  assign in_ready_o = w_ready;

  // Main-register next value: refill from skid in TWO, else take input when
  // the main slot is free (EMPTY) or being vacated this cycle (pop in ONE).
  always_comb begin
    w_load     = 1'b0;
    w_main_nxt = in_data_i;
    w_vld_nxt  = r_vld;
    if (w_state == TWO) begin
      if (w_pop) begin
        w_load     = 1'b1;
        w_main_nxt = w_skid_data;
      end
    end else if (w_accept && ((w_state == EMPTY) || w_pop)) begin
      w_load = 1'b1;
    end
    if (w_accept)                       w_vld_nxt = 1'b1;
    else if (w_pop && (w_state != TWO)) w_vld_nxt = 1'b0;
  end
`else
  assign in_ready_o = !r_vld || out_ready_i;

  // Main-register next value for the single-entry stage.
  always_comb begin
    w_load     = 1'b0;
    w_main_nxt = in_data_i;
    w_vld_nxt  = r_vld;
    if (w_accept) begin
      w_load    = 1'b1;
      w_vld_nxt = 1'b1;
    end else if (w_pop) begin
      w_vld_nxt = 1'b0;
    end
  end
`endif

  // Output flops: reset beats flush beats handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_main <= RST_DATA;
      r_vld  <= 1'b0;
    end else if (flush_i) begin
      r_main <= RST_DATA;
      r_vld  <= 1'b0;
    end else begin
      if (w_load) r_main <= w_main_nxt;
      r_vld <= w_vld_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (8-bit payload).
// Runs the skid-buffer scenarios when PIPE_STAGE_SKID_EN is defined, and the
// combinational-ready scenarios otherwise.
module tb_pipe_stage_elastic;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH    (W),
    .RST_DATA ('0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with input offered
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    step();
    step();
    check("rst_valid_in_reset", {7'd0, out_valid}, 8'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_data", out_data, 8'h00);
    check("rst_ready", {7'd0, in_ready}, 8'd1);

    // Streaming 0x01..0x10 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      check($sformatf("stream_valid_%0d", i), {7'd0, out_valid}, 8'd1);
      check($sformatf("stream_data_%0d", i), out_data, 8'(i));
      check($sformatf("stream_ready_%0d", i), {7'd0, in_ready}, 8'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", {7'd0, out_valid}, 8'd0);

    // Simultaneous accept and pop: 0x55 held, 0x66 offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    step();
    check("ap_hold_data", out_data, 8'h55);
    out_ready = 1'b1; in_data = 8'h66;
    #1;
    check("ap_ready", {7'd0, in_ready}, 8'd1);
    step();
    check("ap_new_data", out_data, 8'h66);
    check("ap_new_valid", {7'd0, out_valid}, 8'd1);
    in_valid = 1'b0;
    step();
    check("ap_drain_valid", {7'd0, out_valid}, 8'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure: A, B fill both entries, C refused
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    step();
    check("bp_a_data", out_data, 8'hA1);
    check("bp_a_ready", {7'd0, in_ready}, 8'd1);
    in_data = 8'hB2;
    step();
    check("bp_b_hold", out_data, 8'hA1);
    check("bp_b_ready", {7'd0, in_ready}, 8'd0);
    in_data = 8'hC3;
    step();
    check("bp_c_hold", out_data, 8'hA1);
    check("bp_c_valid", {7'd0, out_valid}, 8'd1);
    check("bp_c_ready", {7'd0, in_ready}, 8'd0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_registered", {7'd0, in_ready}, 8'd0);
    step();
    check("bp_out_b", out_data, 8'hB2);
    check("bp_ready_back", {7'd0, in_ready}, 8'd1);
    step();
    check("bp_out_c", out_data, 8'hC3);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", {7'd0, out_valid}, 8'd0);

    // Flush while in TWO with D offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE1;
    step();
    in_data = 8'hE2;
    step();
    check("fl_two_ready", {7'd0, in_ready}, 8'd0);
    in_data = 8'hDD; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {7'd0, out_valid}, 8'd0);
    check("fl_data", out_data, 8'h00);
    check("fl_ready", {7'd0, in_ready}, 8'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_d", {7'd0, out_valid}, 8'd0);
    in_valid = 1'b1; in_data = 8'hF0;
    step();
    check("fl_after_data", out_data, 8'hF0);
    in_valid = 1'b0;
    step();
`else
    // Combinational ready follows downstream ready when full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    check("nc_full_data", out_data, 8'h77);
    check("nc_ready_low", {7'd0, in_ready}, 8'd0);
    out_ready = 1'b1;
    #1;
    check("nc_ready_comb", {7'd0, in_ready}, 8'd1);
    step();
    check("nc_pop_valid", {7'd0, out_valid}, 8'd0);

    // Stalled output holds and refuses new input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h88;
    step();
    in_data = 8'h99;
    step();
    check("nc_hold_data", out_data, 8'h88);
    check("nc_hold_valid", {7'd0, out_valid}, 8'd1);

    // Flush with input offered discards both
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("nc_fl_valid", {7'd0, out_valid}, 8'd0);
    check("nc_fl_data", out_data, 8'h00);
    check("nc_fl_ready", {7'd0, in_ready}, 8'd1);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
